gate_sweep_ctrl: RTL
====================

// Module: gate_sweep_ctrl
// PURPOSE
//   Self-checking stimulus sequencer for a small combinational gate under test.
//   On start, walks every input combination in ascending binary order and drives it on gate_in.
//   Holds each vector, samples gate_out and compares it with an expected truth table.
//   Reports per-vector failures and overall pass/fail. Replaces hand-written #delay stimulus with on-chip sweeps.
// PARAMETERS
//   N_IN         2        gate input count; N_VEC = 2**N_IN vectors (1..4 supported)
//   HOLD_CYCLES  2        cycles each vector is held before sampling (>=1)
//   EXP_TT       4'b1000  expected output; bit i = gate_out for gate_in==i (default = AND)
// PORTS
//   clk         in   1                    rising-edge clock
//   rst         in   1                    asynchronous, active-high reset
//   start       in   1                    single-cycle request; sampled only in IDLE
//   gate_out    in   1                    output of gate under test
//   gate_in     out  N_IN                 vector driven to gate under test
//   busy        out  1                    high from the cycle after start until FINISH exits
//   done        out  1                    one-cycle pulse in FINISH
//   pass        out  1                    1 iff last completed sweep had zero failures
//   fail_count  out  $clog2(N_VEC+1)      failing vectors in current/last sweep
//   fail_vec    out  N_VEC                bit i set if vector i mismatched
// BEHAVIOUR
//   Reset (async assert, sync deassert by system): state=IDLE; gate_in=0, busy=0, done=0, pass=0,
//     fail_count=0, fail_vec=0, idx=0, hold_cnt=0. All outputs are registered.
//   FSM states: IDLE, DRIVE, CHECK, FINISH.
//   IDLE: start=1 -> DRIVE; idx=0, hold_cnt=0, fail_count=0, fail_vec=0, pass=0, gate_in=0.
//   DRIVE: gate_in=idx; hold_cnt increments each cycle; at hold_cnt==HOLD_CYCLES-1 -> CHECK.
//   CHECK: compare gate_out with EXP_TT[idx] (gate_in is still idx).
//     Mismatch: fail_vec[idx]<=1, fail_count<=fail_count+1.
//     idx==N_VEC-1 -> FINISH; else idx<=idx+1, hold_cnt<=0, -> DRIVE.
//   FINISH: done=1 for exactly one cycle; pass<=(fail_count==0) including the final CHECK update;
//     -> IDLE. busy drops on the same edge.
//   pass, fail_count and fail_vec hold their values in IDLE until the next accepted start.
//   gate_in holds its last vector in IDLE.
//   Latency: done is high on the N_VEC*(HOLD_CYCLES+1)+1-th rising edge after the edge that accepts start.
//     This is 13 for the defaults.
//   start outside IDLE is ignored, including start during FINISH.
//   A start in the first IDLE cycle after FINISH is accepted and clears the results.
//   Reset mid-sweep aborts immediately to the reset values. No done pulse is issued.
//   idx width is N_IN+1 bits, so the last-vector compare never wraps.
//   fail_count saturates naturally at N_VEC; no overflow is possible.
// STRUCTURE
//   gate_sweep_defs.vh: FSM state localparams (2-bit encoding) and the N_VEC derivation macro.
//     Shared with the bench.
//   Sub-module settle_timer (HOLD_CYCLES counter with clear and expire outputs) is instantiated
//     once for hold_cnt.
//   The rest is a single FSM always block plus registered outputs. Target size is about 150 lines.
// TESTING  (bench wraps the controller around a behavioural gate; clk period 2; one log line per done)
//   1. AND gate, defaults, start pulse.
//      -> gate_in steps 0,1,2,3 for 3 cycles each; done at edge 13; pass=1, fail_count=0, fail_vec=4'b0000.
//   2. OR gate with EXP_TT=4'b1000.
//      -> fail_vec=4'b0110, fail_count=2, pass=0.
//   3. Stuck-at-0 output.
//      -> fail_vec=4'b1000, fail_count=1, pass=0.
//   4. Assert rst while gate_in==2.
//      -> gate_in=0, busy=0, counters 0 the same cycle; no done pulse; a new start gives the same result as scenario 1.
//   5. start pulses mid-sweep and during FINISH.
//      -> sweep unaffected, single done. start in the next IDLE cycle restarts and clears fail_vec.
//   6. N_IN=1, HOLD_CYCLES=1, EXP_TT=2'b01 (NOT gate).
//      -> done at edge 5, pass=1. Inverting the model output gives fail_vec=2'b11.

Source files
------------

// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep controller: FSM state encoding and vector-count helper.
package gate_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StCheck  = 2'd2,
        StFinish = 2'd3
    } state_e;

    function automatic int unsigned n_vec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Hold counter: counts while enabled, clears on request, flags the last hold cycle.
module gate_sweep_ctrl_settle_timer #(
    parameter int unsigned Cycles = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expire_o = (cnt_q == CntW'(Cycles - 1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input combination of a small gate in ascending order and checks its output
// against an expected truth table, reporting per-vector failures and overall pass/fail.
module gate_sweep_ctrl
    import gate_sweep_ctrl_pkg::*;
#(
    parameter int unsigned            N_IN        = 2,
    parameter int unsigned            HOLD_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0]   EXP_TT      = 4'b1000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic                                 gate_out_i,
    output logic [N_IN-1:0]                      gate_in_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 pass_o,
    output logic [$clog2(n_vec(N_IN)+1)-1:0]     fail_count_o,
    output logic [n_vec(N_IN)-1:0]               fail_vec_o
);

    localparam int unsigned NVec = n_vec(N_IN);
    localparam int unsigned CntW = $clog2(NVec + 1);
    localparam int unsigned IdxW = N_IN + 1;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW-1:0]   idx_nxt;
    logic [N_IN-1:0]   gate_in_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CntW-1:0]   fail_count_q;
    logic [NVec-1:0]   fail_vec_q;
    logic              hold_expire;
    logic              mismatch;

    // Hold counter only runs in DRIVE; every other state keeps it cleared.
    gate_sweep_ctrl_settle_timer #(
        .Cycles (HOLD_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != StDrive),
        .en_i     (state_q == StDrive),
        .expire_o (hold_expire)
    );

    assign idx_nxt  = idx_q + IdxW'(1);
    assign mismatch = (gate_out_i != EXP_TT[idx_q[N_IN-1:0]]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            gate_in_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            fail_vec_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q      <= StDrive;
                        idx_q        <= '0;
                        gate_in_q    <= '0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        fail_count_q <= '0;
                        fail_vec_q   <= '0;
                    end
                end
                StDrive: begin
                    if (hold_expire) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        fail_vec_q[idx_q[N_IN-1:0]] <= 1'b1;
                        fail_count_q                <= fail_count_q + CntW'(1);
                    end
                    if (idx_q == IdxW'(NVec - 1)) begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                        // Fold in this cycle's compare so pass is valid alongside done.
                        pass_q  <= (fail_count_q == '0) && !mismatch;
                    end else begin
                        state_q   <= StDrive;
                        idx_q     <= idx_nxt;
                        gate_in_q <= idx_nxt[N_IN-1:0];
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gate_in_o    = gate_in_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign fail_count_o = fail_count_q;
    assign fail_vec_o   = fail_vec_q;

endmodule
